// File: rtl/adder_pkg.sv
// Shared definitions for the 8-bit adder and its downstream frame accumulator:
// width constants, accumulator FSM states and the saturating add helper.
package adder_pkg;

    localparam int OPERAND_W = 8;
    localparam int SUM_W     = OPERAND_W + 1;
    localparam int SAT_MAX_W = 32;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } acc_state_e;

    // Returns {overflow, value}; value is clamped to 2^acc_w-1 (acc_w <= SAT_MAX_W).
    function automatic logic [SAT_MAX_W:0] sat_add(
        input logic [SAT_MAX_W-1:0] acc,
        input logic [SAT_MAX_W-1:0] sum,
        input int                   acc_w
    );
        logic [SAT_MAX_W:0] full;
        logic [SAT_MAX_W:0] limit;
        full  = {1'b0, acc} + {1'b0, sum};
        limit = ((SAT_MAX_W+1)'(1) << acc_w) - (SAT_MAX_W+1)'(1);
        if (full > limit) begin
            return {1'b1, limit[SAT_MAX_W-1:0]};
        end
        return {1'b0, full[SAT_MAX_W-1:0]};
    endfunction

endpackage

// File: rtl/sum_frame_accumulator.sv
// Accumulates the adder's sum stream into frames and presents each frame's
// saturated total, sample count and overflow flag through a valid/ready register.
module sum_frame_accumulator
    import adder_pkg::*;
#(
    parameter int IN_W    = SUM_W,
    parameter int ACC_W   = 16,
    parameter int MAX_LEN = 16,
    parameter int CNT_W   = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sum_valid,
    input  logic [IN_W-1:0]  sum,
    input  logic             frame_last,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [ACC_W-1:0] res_sum,
    output logic [CNT_W-1:0] res_count,
    output logic             res_overflow,
    output logic             frame_drop
);

    acc_state_e         state;
    logic [ACC_W-1:0]   acc;
    logic [CNT_W-1:0]   cnt;
    logic               ovf;

    logic [ACC_W-1:0]   acc_base;
    logic [CNT_W-1:0]   cnt_base;
    logic               ovf_base;
    logic [SAT_MAX_W:0] wide;
    logic [ACC_W-1:0]   acc_next;
    logic [CNT_W-1:0]   cnt_next;
    logic               ovf_next;
    logic               close;
    logic               load;

    // Stage 0: candidate frame result from the current sample
    always_comb begin
        acc_base = (state == IDLE) ? '0 : acc;
        cnt_base = (state == IDLE) ? '0 : cnt;
        ovf_base = (state == IDLE) ? 1'b0 : ovf;
        wide     = sat_add(SAT_MAX_W'(acc_base), SAT_MAX_W'(sum), ACC_W);
        acc_next = ACC_W'(wide);
        ovf_next = wide[SAT_MAX_W] | ovf_base;
        cnt_next = cnt_base + CNT_W'(1);
        close    = sum_valid && (frame_last || (cnt_next == CNT_W'(MAX_LEN)));
        load     = close && (!res_valid || res_ready);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else if (sum_valid) begin
            if (close) begin
                state <= IDLE;
                acc   <= '0;
                cnt   <= '0;
                ovf   <= 1'b0;
            end else begin
                state <= ACCUM;
                acc   <= acc_next;
                cnt   <= cnt_next;
                ovf   <= ovf_next;
            end
        end
    end

    // Stage 1: output register; a close into an occupied, stalled slot is dropped
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_valid    <= 1'b0;
            res_sum      <= '0;
            res_count    <= '0;
            res_overflow <= 1'b0;
            frame_drop   <= 1'b0;
        end else begin
            frame_drop <= close && res_valid && !res_ready;
            if (load) begin
                res_valid    <= 1'b1;
                res_sum      <= acc_next;
                res_count    <= cnt_next;
                res_overflow <= ovf_next;
            end else if (res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sum_frame_accumulator.sv
// Bench for sum_frame_accumulator: directed scenarios on 16- and 12-bit
// accumulator instances plus a randomized stream against a frame-level model.
module tb_sum_frame_accumulator;

    logic        clk = 1'b0;
    logic        reset;
    logic        sum_valid;
    logic [8:0]  sum;
    logic        frame_last;
    logic        res_ready;

    logic        res_valid;
    logic [15:0] res_sum;
    logic [4:0]  res_count;
    logic        res_overflow;
    logic        frame_drop;

    logic        b_res_valid;
    logic [11:0] b_res_sum;
    logic [4:0]  b_res_count;
    logic        b_res_overflow;
    logic        b_frame_drop;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sum_frame_accumulator #(.IN_W(9), .ACC_W(16), .MAX_LEN(16)) dut (
        .clk(clk), .reset(reset), .sum_valid(sum_valid), .sum(sum),
        .frame_last(frame_last), .res_valid(res_valid), .res_ready(res_ready),
        .res_sum(res_sum), .res_count(res_count), .res_overflow(res_overflow),
        .frame_drop(frame_drop)
    );

    sum_frame_accumulator #(.IN_W(9), .ACC_W(12), .MAX_LEN(16)) dut12 (
        .clk(clk), .reset(reset), .sum_valid(sum_valid), .sum(sum),
        .frame_last(frame_last), .res_valid(b_res_valid), .res_ready(res_ready),
        .res_sum(b_res_sum), .res_count(b_res_count), .res_overflow(b_res_overflow),
        .frame_drop(b_frame_drop)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input int s, input logic l);
        sum_valid  = v;
        sum        = 9'(s);
        frame_last = l;
    endtask

    task automatic sample(input int s, input logic l);
        drive(1'b1, s, l);
        tick();
        drive(1'b0, 0, 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b1; res_ready = 1'b0;
        drive(1'b0, 0, 1'b0);
        tick(); tick();
        checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", res_valid); end
        checks++; if (res_sum !== 16'd0) begin failures++; $display("FAIL reset_sum got=%0d exp=0", res_sum); end
        checks++; if (res_count !== 5'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", res_count); end
        checks++; if (res_overflow !== 1'b0 || frame_drop !== 1'b0) begin failures++; $display("FAIL reset_flags got=%0b%0b exp=00", res_overflow, frame_drop); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int vals[4] = '{10, 20, 30, 40};
        res_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sample(vals[i], i == 3);
            if (i < 3) begin
                checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL basic_early_valid i=%0d got=%0b exp=0", i, res_valid); end
            end
        end
        checks++; if (res_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%0b exp=1", res_valid); end
        checks++; if (res_sum !== 16'd100) begin failures++; $display("FAIL basic_sum got=%0d exp=100", res_sum); end
        checks++; if (res_count !== 5'd4) begin failures++; $display("FAIL basic_count got=%0d exp=4", res_count); end
        checks++; if (res_overflow !== 1'b0) begin failures++; $display("FAIL basic_ovf got=%0b exp=0", res_overflow); end
        tick();
        checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL basic_consumed got=%0b exp=0", res_valid); end
    endtask

    task automatic test_auto_close();
        res_ready = 1'b1;
        for (int i = 0; i < 16; i++) sample(510, 1'b0);
        checks++; if (res_valid !== 1'b1) begin failures++; $display("FAIL auto_valid got=%0b exp=1", res_valid); end
        checks++; if (res_sum !== 16'd8160) begin failures++; $display("FAIL auto_sum got=%0d exp=8160", res_sum); end
        checks++; if (res_count !== 5'd16) begin failures++; $display("FAIL auto_count got=%0d exp=16", res_count); end
        sample(5, 1'b1);
        checks++; if (res_valid !== 1'b1 || res_sum !== 16'd5) begin failures++; $display("FAIL auto_next_sum got=%0b/%0d exp=1/5", res_valid, res_sum); end
        checks++; if (res_count !== 5'd1) begin failures++; $display("FAIL auto_next_count got=%0d exp=1", res_count); end
        tick();
    endtask

    task automatic test_overflow();
        res_ready = 1'b1;
        for (int i = 0; i < 9; i++) sample(510, i == 8);
        checks++; if (b_res_sum !== 12'd4095) begin failures++; $display("FAIL ovf_sum got=%0d exp=4095", b_res_sum); end
        checks++; if (b_res_overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%0b exp=1", b_res_overflow); end
        checks++; if (b_res_count !== 5'd9) begin failures++; $display("FAIL ovf_count got=%0d exp=9", b_res_count); end
        checks++; if (res_sum !== 16'd4590 || res_overflow !== 1'b0) begin failures++; $display("FAIL ovf_wide got=%0d/%0b exp=4590/0", res_sum, res_overflow); end
        sample(3, 1'b1);
        checks++; if (b_res_sum !== 12'd3 || b_res_overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%0d/%0b exp=3/0", b_res_sum, b_res_overflow); end
        tick();
    endtask

    task automatic test_drop();
        res_ready = 1'b0;
        sample(7, 1'b1);
        checks++; if (res_valid !== 1'b1 || res_sum !== 16'd7) begin failures++; $display("FAIL drop_held got=%0b/%0d exp=1/7", res_valid, res_sum); end
        sample(9, 1'b1);
        checks++; if (frame_drop !== 1'b1) begin failures++; $display("FAIL drop_pulse got=%0b exp=1", frame_drop); end
        checks++; if (res_sum !== 16'd7 || res_count !== 5'd1) begin failures++; $display("FAIL drop_stable got=%0d/%0d exp=7/1", res_sum, res_count); end
        tick();
        checks++; if (frame_drop !== 1'b0) begin failures++; $display("FAIL drop_one_cycle got=%0b exp=0", frame_drop); end
        checks++; if (res_valid !== 1'b1 || res_sum !== 16'd7) begin failures++; $display("FAIL drop_hold2 got=%0b/%0d exp=1/7", res_valid, res_sum); end
        res_ready = 1'b1;
        tick();
        checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL drop_consume got=%0b exp=0", res_valid); end
    endtask

    task automatic test_back_to_back();
        res_ready = 1'b0;
        sample(7, 1'b1);
        sample(2, 1'b0);
        res_ready = 1'b1;
        sample(3, 1'b1);
        checks++; if (res_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid got=%0b exp=1", res_valid); end
        checks++; if (res_sum !== 16'd5 || res_count !== 5'd2) begin failures++; $display("FAIL b2b_sum got=%0d/%0d exp=5/2", res_sum, res_count); end
        checks++; if (frame_drop !== 1'b0) begin failures++; $display("FAIL b2b_drop got=%0b exp=0", frame_drop); end
        tick();
        checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL b2b_consume got=%0b exp=0", res_valid); end
    endtask

    task automatic test_gaps();
        res_ready = 1'b1;
        sample(4, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 0, 1'b1);
            tick();
            checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL gap_valid i=%0d got=%0b exp=0", i, res_valid); end
        end
        sample(6, 1'b1);
        checks++; if (res_valid !== 1'b1 || res_sum !== 16'd10 || res_count !== 5'd2) begin failures++; $display("FAIL gap_result got=%0b/%0d/%0d exp=1/10/2", res_valid, res_sum, res_count); end
        tick();
    endtask

    task automatic test_reset_mid();
        res_ready = 1'b0;
        sample(1, 1'b0);
        sample(2, 1'b0);
        reset = 1'b1;
        #2;
        reset = 1'b0;
        checks++; if (res_valid !== 1'b0 || res_sum !== 16'd0) begin failures++; $display("FAIL mid_reset_out got=%0b/%0d exp=0/0", res_valid, res_sum); end
        res_ready = 1'b1;
        sample(8, 1'b1);
        checks++; if (res_sum !== 16'd8 || res_count !== 5'd1) begin failures++; $display("FAIL mid_reset_frame got=%0d/%0d exp=8/1", res_sum, res_count); end
        tick();
    endtask

    task automatic test_random();
        int fsum = 0, fcnt = 0;
        bit slot_v = 0, slot_o12 = 0, drop_exp;
        int slot_s16 = 0, slot_s12 = 0, slot_c = 0;
        bit v, l, r;
        int s;
        for (int cyc = 0; cyc < 600; cyc++) begin
            v = ($urandom_range(0, 3) != 0);
            s = int'($urandom_range(0, 511));
            l = ($urandom_range(0, 5) == 0);
            r = ($urandom_range(0, 2) != 0);
            drop_exp = 0;
            if (v) begin
                fsum += s;
                fcnt += 1;
            end
            if (v && (l || fcnt == 16)) begin
                if (!slot_v || r) begin
                    slot_v   = 1;
                    slot_s16 = (fsum > 65535) ? 65535 : fsum;
                    slot_s12 = (fsum > 4095) ? 4095 : fsum;
                    slot_o12 = (fsum > 4095);
                    slot_c   = fcnt;
                end else begin
                    drop_exp = 1;
                end
                fsum = 0;
                fcnt = 0;
            end else if (r) begin
                slot_v = 0;
            end
            res_ready = r;
            drive(v, s, l);
            tick();
            checks++; if (res_valid !== slot_v || frame_drop !== drop_exp) begin failures++; $display("FAIL rand_ctrl cyc=%0d got=%0b/%0b exp=%0b/%0b", cyc, res_valid, frame_drop, slot_v, drop_exp); end
            if (slot_v) begin
                checks++; if (res_sum !== 16'(slot_s16) || res_count !== 5'(slot_c) || res_overflow !== 1'b0) begin failures++; $display("FAIL rand_data16 cyc=%0d got=%0d/%0d/%0b exp=%0d/%0d/0", cyc, res_sum, res_count, res_overflow, slot_s16, slot_c); end
                checks++; if (b_res_sum !== 12'(slot_s12) || b_res_overflow !== slot_o12) begin failures++; $display("FAIL rand_data12 cyc=%0d got=%0d/%0b exp=%0d/%0b", cyc, b_res_sum, b_res_overflow, slot_s12, slot_o12); end
            end
        end
        drive(1'b0, 0, 1'b0);
        res_ready = 1'b1;
        tick();
    endtask

    initial begin
        reset = 1'b1;
        res_ready = 1'b0;
        drive(1'b0, 0, 1'b0);
        test_reset();
        test_basic();
        test_auto_close();
        test_overflow();
        test_drop();
        test_back_to_back();
        test_gaps();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sum_frame_accumulator.md
Name: sum_frame_accumulator

Overview:
- Downstream consumer of the 8-bit adder's registered 9-bit sum stream.
- Accumulates consecutive valid sums into frames, closed by a frame_last marker or a length limit.
- Presents each frame's total, sample count and overflow flag through a valid/ready output register.
- Input side has no backpressure, because the adder cannot stall. Output contention is reported as a dropped frame.

Parameters:
- IN_W, 9, width of incoming sum (adder output width)
- ACC_W, 16, accumulator/result width; must be greater than IN_W
- MAX_LEN, 16, maximum samples per frame; the frame auto-closes on reaching it
- CNT_W, $clog2(MAX_LEN+1), sample-count width (derived, not overridden)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- sum_valid  in  1  sum is a valid sample this cycle
- sum  in  IN_W  adder result
- frame_last  in  1  current sample ends the frame; qualified by sum_valid
- res_valid  out  1  result register holds an unconsumed frame
- res_ready  in  1  downstream accepts the result
- res_sum  out  ACC_W  frame total, saturated
- res_count  out  CNT_W  samples in frame (1..MAX_LEN)
- res_overflow  out  1  frame total saturated
- frame_drop  out  1  one-cycle pulse: completed frame discarded because the output was occupied

Behaviour:
- Reset values: res_valid=0, res_sum=0, res_count=0, res_overflow=0, frame_drop=0, accumulator=0, count=0, state IDLE.
- Reset mid-frame discards the partial frame and any held result.
- Accumulator FSM states:
  - IDLE: no samples in the current frame.
  - ACCUM: at least one sample held.
- Sample accepted when sum_valid=1, every cycle, in either state. next_acc = sat(acc + zero-extended sum).
  - Saturation clamps at 2^ACC_W-1 and sets the sticky frame overflow bit.
  - In IDLE, acc is treated as 0 and the overflow bit as 0.
- Frame close when an accepted sample has frame_last=1, or count+1 == MAX_LEN.
  - next_acc, count+1 and the overflow bit go to the output candidate.
  - Accumulator and count clear to 0; FSM goes to IDLE.
  - A sample in the cycle after a close starts a new frame with no gap.
- Without a close, an accepted sample moves the FSM to ACCUM.
- sum_valid=0 leaves state unchanged; frame_last is ignored when sum_valid=0.
- Latency: result registers and res_valid=1 on the clock edge that samples the closing input. Visible one cycle after the closing sample is presented.
- Output register rules:
  - Load candidate if res_valid=0, or if res_valid=1 and res_ready=1 in the same cycle. In the second case res_valid stays 1 with new contents; no bubble, no drop.
  - Close while res_valid=1 and res_ready=0: candidate discarded, held result unchanged, frame_drop=1 for exactly one cycle.
  - res_ready=1 with no close: res_valid→0 next cycle. Data fields hold their last values.
  - Held result fields are stable while res_valid=1 and res_ready=0.
- Single-sample frame: res_sum=sum, res_count=1.
- Width rule: no wrap-around anywhere; count never exceeds MAX_LEN.

Decomposition:
- Shared package adder_pkg:
  - operand/sum width constants (8, 9)
  - accumulator FSM state enum {IDLE, ACCUM}
  - pure function sat_add(acc, sum) returning {overflow, value}
- No sub-module: a single module with the FSM and output register.

Test Plan:
- Samples 10,20,30,40 back-to-back, frame_last on 40, res_ready=1 → res_valid one cycle later, res_sum=100, res_count=4, res_overflow=0; res_valid low the following cycle.
- 16 samples of 510 with no frame_last → auto-close on 16th, res_sum=8160, res_count=16. A 17th sample of 5 with frame_last → next result res_sum=5, res_count=1.
- Instance with ACC_W=12: nine samples of 510, last on ninth → res_sum=4095, res_overflow=1, res_count=9. Next frame of 1 sample of 3 → res_sum=3, res_overflow=0.
- res_ready=0; frame A {7} then frame B {9} closes → frame_drop pulses once, res_sum stays 7. Then res_ready=1 → A consumed, res_valid=0.
- res_valid=1 holding 7 with res_ready=1 in the same cycle a frame {2,3} closes → res_valid stays 1, res_sum=5, frame_drop=0.
- sum_valid gaps (sample 4, three idle cycles with frame_last=1 and sum_valid=0, then sample 6 with last) → single result 10, count 2. Separately, reset asserted mid-frame after samples 1,2 then frame {8} → result 8, count 1.
